// File: rtl/led_fader_pkg.sv
// Shared types and ramp arithmetic for the LED PWM fader.
// The step helper works on a fixed wide word so that any PWM_BITS up to 16 can use it.
package led_fader_pkg;

   localparam int DEF_PWM_BITS = 8;
   localparam int ARITH_W      = 16;

   typedef logic [DEF_PWM_BITS-1:0] duty_t;

   // Moves duty one step toward target without overshooting; one extra bit of headroom avoids wrap.
   function automatic logic [ARITH_W-1:0] step_toward(input logic [ARITH_W-1:0] duty,
                                                      input logic [ARITH_W-1:0] target,
                                                      input logic [ARITH_W-1:0] step);
      logic [ARITH_W:0] up;
      logic [ARITH_W:0] floor_lim;
      logic [ARITH_W-1:0] res;
      up        = {1'b0, duty} + {1'b0, step};
      floor_lim = {1'b0, target} + {1'b0, step};
      res       = duty;
      if (duty < target) begin
         res = (up > {1'b0, target}) ? target : up[ARITH_W-1:0];
      end else if (duty > target) begin
         res = ({1'b0, duty} < floor_lim) ? target : (duty - step);
      end
      return res;
   endfunction

endpackage

// File: rtl/led_fader_channel.sv
// One LED channel: ramped duty, period-aligned applied duty and registered PWM compare.
module led_fader_channel
   import led_fader_pkg::*;
#(
   parameter int PWM_BITS  = DEF_PWM_BITS,
   parameter int MAX_LEVEL = 255,
   parameter int STEP      = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                led_i,
   input  logic                tick_i,
   input  logic                load_i,
   input  logic [PWM_BITS-1:0] pwm_cnt_i,
   output logic                led_o,
   output logic                mismatch_o
);

   localparam logic [PWM_BITS-1:0] LEVEL_ON = PWM_BITS'(MAX_LEVEL);

   logic [PWM_BITS-1:0] target;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic [PWM_BITS-1:0] applied_q, applied_d;
   logic                led_q, led_d;

   // The applied duty captures the pre-tick ramp value, so a coincident tick lands one period later.
   always_comb begin
      target    = led_i ? LEVEL_ON : '0;
      duty_d    = duty_q;
      if (tick_i) begin
         duty_d = PWM_BITS'(step_toward(ARITH_W'(duty_q), ARITH_W'(target), ARITH_W'(STEP)));
      end
      applied_d = load_i ? duty_q : applied_q;
      led_d     = (applied_q > pwm_cnt_i);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         duty_q    <= '0;
         applied_q <= '0;
         led_q     <= 1'b0;
      end else begin
         duty_q    <= duty_d;
         applied_q <= applied_d;
         led_q     <= led_d;
      end
   end

   assign led_o      = led_q;
   assign mismatch_o = (duty_q != target);

endmodule

// File: rtl/led_pwm_fader.sv
// PWM fader between the core's LED pattern and the board pins.
// Shared PWM counter and ramp prescaler live here; each LED is one led_fader_channel.
module led_pwm_fader
   import led_fader_pkg::*;
#(
   parameter int NUM_LEDS  = 4,
   parameter int PWM_BITS  = DEF_PWM_BITS,
   parameter int MAX_LEVEL = 255,
   parameter int STEP      = 4,
   parameter int RAMP_DIV  = 25000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_LEDS-1:0] led_in,
   output logic [NUM_LEDS-1:0] led_out,
   output logic                busy
);

   localparam int PRESC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [PRESC_W-1:0]  presc_q, presc_d;
   logic                tick;
   logic                load;
   logic [NUM_LEDS-1:0] mismatch;
   logic                busy_q, busy_d;

   always_comb begin
      tick      = (presc_q == PRESC_W'(RAMP_DIV - 1));
      presc_d   = tick ? '0 : presc_q + 1'b1;
      pwm_cnt_d = pwm_cnt_q + 1'b1;
      load      = (pwm_cnt_q == '1);
      busy_d    = |mismatch;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pwm_cnt_q <= '0;
         presc_q   <= '0;
         busy_q    <= 1'b0;
      end else begin
         pwm_cnt_q <= pwm_cnt_d;
         presc_q   <= presc_d;
         busy_q    <= busy_d;
      end
   end

   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
      led_fader_channel #(
         .PWM_BITS  (PWM_BITS),
         .MAX_LEVEL (MAX_LEVEL),
         .STEP      (STEP)
      ) u_ch (
         .clk        (clk),
         .reset      (reset),
         .led_i      (led_in[i]),
         .tick_i     (tick),
         .load_i     (load),
         .pwm_cnt_i  (pwm_cnt_q),
         .led_o      (led_out[i]),
         .mismatch_o (mismatch[i])
      );
   end

   assign busy = busy_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Scoreboard bench for led_pwm_fader: three parameter sets share stimulus,
// a cycle model built from the ramp/PWM rules predicts pins and busy.
module tb_led_pwm_fader;

   localparam int NCFG   = 3;
   localparam int PERIOD = 16;
   localparam int RDIV   = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] led_in = 4'b0000;
   logic [3:0] led_a, led_b, led_c;
   logic       busy_a, busy_b, busy_c;

   typedef struct packed {
      logic [NCFG-1:0][3:0] led;
      logic [NCFG-1:0]      busy;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;

   // Reference state: config 0 = STEP 1 cap 15, 1 = STEP 4 cap 15, 2 = STEP 1 cap 8
   int maxl[NCFG] = '{15, 15, 8};
   int stp[NCFG]  = '{1, 4, 1};
   int duty[NCFG][4];
   int applied[NCFG][4];
   int n = 0;

   always #5 clk = ~clk;

   led_pwm_fader #(.NUM_LEDS(4), .PWM_BITS(4), .MAX_LEVEL(15), .STEP(1), .RAMP_DIV(RDIV)) u_a (
      .clk(clk), .reset(reset), .led_in(led_in), .led_out(led_a), .busy(busy_a));
   led_pwm_fader #(.NUM_LEDS(4), .PWM_BITS(4), .MAX_LEVEL(15), .STEP(4), .RAMP_DIV(RDIV)) u_b (
      .clk(clk), .reset(reset), .led_in(led_in), .led_out(led_b), .busy(busy_b));
   led_pwm_fader #(.NUM_LEDS(4), .PWM_BITS(4), .MAX_LEVEL(8), .STEP(1), .RAMP_DIV(RDIV)) u_c (
      .clk(clk), .reset(reset), .led_in(led_in), .led_out(led_c), .busy(busy_c));

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0d (0x%0h) expected %0d (0x%0h)", nm, cyc, act, act, exp, exp);
      end
   endtask

   // Predict what the next clock edge produces, then advance the model.
   task automatic model_edge(input logic r, input logic [3:0] li, output exp_t e);
      int pc;
      int tgt;
      e = '0;
      if (r) begin
         for (int c = 0; c < NCFG; c++)
            for (int i = 0; i < 4; i++) begin
               duty[c][i]    = 0;
               applied[c][i] = 0;
            end
         n = 0;
      end else begin
         pc = n % PERIOD;
         for (int c = 0; c < NCFG; c++) begin
            for (int i = 0; i < 4; i++) begin
               tgt = li[i] ? maxl[c] : 0;
               e.led[c][i] = (applied[c][i] > pc);
               if (duty[c][i] != tgt) e.busy[c] = 1'b1;
               if (pc == PERIOD - 1) applied[c][i] = duty[c][i];
               if ((n % RDIV) == RDIV - 1) begin
                  if (duty[c][i] < tgt)
                     duty[c][i] = (duty[c][i] + stp[c] > tgt) ? tgt : duty[c][i] + stp[c];
                  else if (duty[c][i] > tgt)
                     duty[c][i] = (duty[c][i] - stp[c] < tgt) ? tgt : duty[c][i] - stp[c];
               end
            end
         end
         n++;
      end
   endtask

   task automatic step(input logic r, input logic [3:0] li);
      exp_t e;
      @(negedge clk);
      reset  = r;
      led_in = li;
      model_edge(r, li, e);
      q.push_back(e);
      cyc++;
   endtask

   task automatic run(input logic r, input logic [3:0] li, input int cycles);
      for (int k = 0; k < cycles; k++) step(r, li);
   endtask

   // Counts high cycles per bit over one full period and checks the bits lit together.
   task automatic measure(input int cfg, input logic [3:0] li, input int exp_cnt, input string nm);
      int         cnt[4];
      int         phase_ok;
      logic [3:0] v;
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      phase_ok = 1;
      for (int k = 0; k < PERIOD; k++) begin
         step(1'b0, li);
         v = (cfg == 0) ? led_a : (cfg == 1) ? led_b : led_c;
         for (int i = 0; i < 4; i++) cnt[i] += int'(v[i]);
         if (((v & li) != 4'b0000) && ((v & li) != li)) phase_ok = 0;
      end
      for (int i = 0; i < 4; i++)
         chk($sformatf("%s_hi%0d", nm, i), cnt[i], li[i] ? exp_cnt : 0);
      chk({nm, "_in_phase"}, phase_ok, 1);
   endtask

   always @(posedge clk) begin
      #1;
      if (q.size() != 0) begin
         mon_e = q.pop_front();
         chk("led_a",  int'(led_a),  int'(mon_e.led[0]));
         chk("busy_a", int'(busy_a), int'(mon_e.busy[0]));
         chk("led_b",  int'(led_b),  int'(mon_e.led[1]));
         chk("busy_b", int'(busy_b), int'(mon_e.busy[1]));
         chk("led_c",  int'(led_c),  int'(mon_e.led[2]));
         chk("busy_c", int'(busy_c), int'(mon_e.busy[2]));
      end
   end

   initial begin
      logic [3:0] li;
      logic       r;
      // Reset held with all requests set
      run(1'b1, 4'b1111, 10);
      // Fade in channel 0 and check steady-state brightness
      run(1'b0, 4'b0001, 100);
      measure(0, 4'b0001, 15, "a_full");
      measure(1, 4'b0001, 15, "b_full");
      // All channels on; config 2 caps at mid-scale
      run(1'b0, 4'b1111, 100);
      measure(2, 4'b1111, 8, "c_mid");
      // Reversal mid-ramp
      run(1'b1, 4'b0000, 2);
      run(1'b0, 4'b0001, 20);
      run(1'b0, 4'b0000, 40);
      // Saturating ramp and fade-out
      run(1'b0, 4'b0010, 80);
      run(1'b0, 4'b0000, 40);
      // Reset mid-fade, ramp restarts from zero
      run(1'b1, 4'b0000, 1);
      run(1'b0, 4'b0001, 28);
      run(1'b1, 4'b0001, 1);
      run(1'b0, 4'b0001, 40);
      // Random patterns with occasional resets
      li = 4'b0000;
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 29) == 0) li = 4'($urandom_range(0, 15));
         r = ($urandom_range(0, 249) == 0);
         step(r, li);
      end
      repeat (3) @(negedge clk);
      chk("sb_drain", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
